// File: rtl/ks_sum_lzc_stage.sv
// Final Kogge-Stone adder stage: sum/carry-out formation, leading-zero count, 2-entry skid buffer.
// Optional macro KS_LZC_EN enables the leading-zero count and zero flag; otherwise both outputs read 0.
module ks_sum_lzc_stage #(
  parameter int unsigned W = 25,
  localparam int unsigned LZW = $clog2(W + 2)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_P0,
  input  logic [W-1:0]   in_GG,
  input  logic           in_sign,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_sum,
  output logic           out_cout,
  output logic           out_sign,
  output logic [LZW-1:0] out_lzc,
  output logic           out_zero
);

`ifdef KS_LZC_EN
  typedef struct packed {
    logic [W-1:0]   sum;
    logic           cout;
    logic           sign;
    logic [LZW-1:0] lzc;
    logic           zero;
  } beat_t;
`else
  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         sign;
  } beat_t;
`endif

  logic [W-1:0] sum_c;
  logic         cout_c;
  beat_t        beat_c;
  beat_t        main_q;
  beat_t        skid_q;
  logic         main_valid;
  logic         skid_valid;
  logic         accept_c;
  logic         main_free_c;

  // Carry into bit i is the prefix generate of bit i-1; carry-in of bit 0 is zero.
  assign sum_c  = in_P0 ^ {in_GG[W-2:0], 1'b0};
  assign cout_c = in_GG[W-1];

`ifdef KS_LZC_EN
  logic [W:0]     total_c;
  logic [LZW-1:0] lzc_c;
  logic           zero_c;

  assign total_c = {cout_c, sum_c};

  // Highest set bit wins because the scan runs upward; all-zero leaves W+1.
  always_comb begin
    lzc_c = LZW'(W + 1);
    for (int unsigned i = 0; i < W + 1; i++) begin
      if (total_c[i]) lzc_c = LZW'(W - i);
    end
  end

  assign zero_c = (total_c == '0);

  always_comb begin
    beat_c      = '0;
    beat_c.sum  = sum_c;
    beat_c.cout = cout_c;
    beat_c.sign = in_sign;
    beat_c.lzc  = lzc_c;
    beat_c.zero = zero_c;
  end
`else
  always_comb begin
    beat_c      = '0;
    beat_c.sum  = sum_c;
    beat_c.cout = cout_c;
    beat_c.sign = in_sign;
  end
`endif

  assign accept_c    = in_valid && !skid_valid;
  assign main_free_c = !main_valid || out_ready;

  // Skid never receives a beat in the same cycle it drains, since accept requires it empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free_c) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept_c;
        if (accept_c) main_q <= beat_c;
      end
    end else if (accept_c) begin
      skid_q     <= beat_c;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_sum   = main_q.sum;
  assign out_cout  = main_q.cout;
  assign out_sign  = main_q.sign;

`ifdef KS_LZC_EN
  assign out_lzc  = main_q.lzc;
  assign out_zero = main_q.zero;
`else
  assign out_lzc  = '0;
  assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_ks_sum_lzc_stage.sv
// Bench for ks_sum_lzc_stage: directed vectors plus a randomized handshake stream against an a+b scoreboard.
module tb_ks_sum_lzc_stage;
  localparam int unsigned W   = 25;
  localparam int unsigned LZW = 5;

  logic           clock;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_P0;
  logic [W-1:0]   in_GG;
  logic           in_sign;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sum;
  logic           out_cout;
  logic           out_sign;
  logic [LZW-1:0] out_lzc;
  logic           out_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sign;
  } rec_t;

  rec_t         sb[$];
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;
  bit           drv_done;

  ks_sum_lzc_stage #(.W(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_P0(in_P0), .in_GG(in_GG), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_sign(out_sign),
    .out_lzc(out_lzc), .out_zero(out_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // GG[i] is the carry out of bit i of a+b, taken from the truncated sums.
  function automatic logic [W-1:0] gen_gg(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] g;
    logic [31:0]  m;
    logic [31:0]  s;
    g = '0;
    for (int i = 0; i < int'(W); i++) begin
      m = (32'd1 << (i + 1)) - 32'd1;
      s = (32'(a) & m) + (32'(b) & m);
      g[i] = s[i + 1];
    end
    return g;
  endfunction

  function automatic int count_lz(input logic [W:0] v);
    int n;
    n = 0;
    for (int i = int'(W); i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bit ok;
    cur_a    = a;
    cur_b    = b;
    in_P0    = a ^ b;
    in_GG    = gen_gg(a, b);
    in_sign  = s;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
    end
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  // Scoreboard: occupancy, head-of-queue data and FIFO order, checked every negedge.
  always @(negedge clock) begin
    logic [W:0] total;
    int         exp_lzc;
    bit         exp_zero;
    if (reset) begin
      sb.delete();
    end else begin
      chk("in_ready_occ", 64'(in_ready), 64'(sb.size() < 2));
      chk("out_valid_occ", 64'(out_valid), 64'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        total = {1'b0, sb[0].a} + {1'b0, sb[0].b};
`ifdef KS_LZC_EN
        exp_lzc  = count_lz(total);
        exp_zero = (total == '0);
`else
        exp_lzc  = 0;
        exp_zero = 1'b0;
`endif
        chk("sb_sum", 64'(out_sum), 64'(total[W-1:0]));
        chk("sb_cout", 64'(out_cout), 64'(total[W]));
        chk("sb_sign", 64'(out_sign), 64'(sb[0].sign));
        chk("sb_lzc", 64'(out_lzc), 64'(exp_lzc));
        chk("sb_zero", 64'(out_zero), 64'(exp_zero));
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back('{a: cur_a, b: cur_b, sign: in_sign});
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_P0     = '0;
    in_GG     = '0;
    in_sign   = 1'b0;
    out_ready = 1'b1;
    cur_a     = '0;
    cur_b     = '0;
    drv_done  = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_lzc", 64'(out_lzc), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 1) 1+1
    send(25'd1, 25'd1, 1'b0);
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_sum", 64'(out_sum), 64'h2);
    chk("t1_cout", 64'(out_cout), 64'd0);
`ifdef KS_LZC_EN
    chk("t1_lzc", 64'(out_lzc), 64'd24);
`else
    chk("t1_lzc", 64'(out_lzc), 64'd0);
`endif
    chk("t1_zero", 64'(out_zero), 64'd0);

    // 2) 0x1FFFFFF+1 wraps to carry-out only
    send(25'h1FFFFFF, 25'd1, 1'b0);
    in_valid = 1'b0;
    chk("t2_sum", 64'(out_sum), 64'h0);
    chk("t2_cout", 64'(out_cout), 64'd1);
    chk("t2_lzc", 64'(out_lzc), 64'd0);
    chk("t2_zero", 64'(out_zero), 64'd0);

    // 3) all-zero result with sign set
    send(25'd0, 25'd0, 1'b1);
    in_valid = 1'b0;
    chk("t3_sum", 64'(out_sum), 64'h0);
    chk("t3_cout", 64'(out_cout), 64'd0);
    chk("t3_sign", 64'(out_sign), 64'd1);
`ifdef KS_LZC_EN
    chk("t3_lzc", 64'(out_lzc), 64'd26);
    chk("t3_zero", 64'(out_zero), 64'd1);
`else
    chk("t3_lzc", 64'(out_lzc), 64'd0);
    chk("t3_zero", 64'(out_zero), 64'd0);
`endif
    @(posedge clock);
    #1;

    // 4) back-pressure: two beats fill both entries, third waits
    out_ready = 1'b0;
    send(25'd1, 25'd0, 1'b0);
    send(25'd2, 25'd0, 1'b0);
    chk("t4_in_ready_low", 64'(in_ready), 64'd0);
    chk("t4_head", 64'(out_sum), 64'd1);
    fork
      send(25'd3, 25'd0, 1'b0);
      begin
        repeat (3) @(posedge clock);
        #1;
        chk("t4_head_held", 64'(out_sum), 64'd1);
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("t4_drained", 64'(out_valid), 64'd0);

    // 5) async reset with both entries full
    out_ready = 1'b0;
    send(25'd4, 25'd0, 1'b1);
    send(25'd5, 25'd0, 1'b1);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_sum", 64'(out_sum), 64'd0);
    chk("t5_sign", 64'(out_sign), 64'd0);
    chk("t5_cout", 64'(out_cout), 64'd0);
    chk("t5_lzc", 64'(out_lzc), 64'd0);
    chk("t5_zero", 64'(out_zero), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    send(25'd7, 25'd0, 1'b0);
    in_valid = 1'b0;
    chk("t5_next_valid", 64'(out_valid), 64'd1);
    chk("t5_next_sum", 64'(out_sum), 64'd7);
    @(posedge clock);
    #1;

    // 6) random stream of 10k beats under random back-pressure
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(posedge clock);
            #1;
          end
          send(W'($urandom), W'($urandom), 1'($urandom_range(1)));
        end
        in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clock);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      @(posedge clock);
      #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
